// File: rtl/spi_multi_slave_exchange.sv
// SPI test vehicle: one master and NUM_SLAVES 8-bit slaves on a shared MOSI/MISO/SCLK bus.
// Reset preloads the master and the chosen slave, then WIDTH LSB-first shifts swap the two bytes.
module spi_multi_slave_exchange #(
  parameter int WIDTH      = 8,
  parameter int NUM_SLAVES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] Master_Input,
  input  logic [WIDTH-1:0] Selected_Slave_Input,
  input  logic [1:0]       choose,
  input  logic             cpah,
  input  logic             cpol,
  output logic [WIDTH-1:0] Master_Output,
  output logic [WIDTH-1:0] Slave_Output,
  output logic [1:0]       Master_Mode
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]      master_sr;
  logic [WIDTH-1:0]      slave_sr [NUM_SLAVES];
  logic [CNT_W-1:0]      bit_cnt;
  logic                  done;
  logic [1:0]            sel;
  logic                  sel_valid;
  logic                  xfer_on;
  logic                  sclk;
  logic                  shift_clk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_SLAVES-1:0] ss_n;

  assign sel_valid = int'(sel) < NUM_SLAVES;
  assign xfer_on   = !reset && !done && sel_valid;
  assign sclk      = xfer_on ? (clk ^ cpol) : cpol;

  // Modes 1/2 shift on the falling clk edge, modes 0/3 on the rising edge.
  // Both mux legs are equal while sclk toggles, so switching legs cannot glitch.
  assign shift_clk = xfer_on ? (sclk ^ cpah) : (clk ^ cpol ^ cpah);
  assign mosi      = master_sr[0];

  always_comb begin
    miso = 1'b0;
    ss_n = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (xfer_on && int'(sel) == i) begin
        ss_n[i] = 1'b0;
        miso    = slave_sr[i][0];
      end
    end
  end

  // Reset doubles as the parallel-load strobe; the slave choice is frozen at release.
  always_ff @(posedge shift_clk or posedge reset) begin
    if (reset) begin
      master_sr <= Master_Input;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (int'(choose) == i) slave_sr[i] <= Selected_Slave_Input;
      end
      bit_cnt <= '0;
      done    <= 1'b0;
      sel     <= choose;
    end else if (xfer_on) begin
      master_sr <= {miso, master_sr[WIDTH-1:1]};
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (!ss_n[i]) slave_sr[i] <= {mosi, slave_sr[i][WIDTH-1:1]};
      end
      bit_cnt <= bit_cnt + 1'b1;
      if (bit_cnt == CNT_W'(WIDTH - 1)) done <= 1'b1;
    end
  end

  always_comb begin
    Slave_Output = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(choose) == i) Slave_Output = slave_sr[i];
    end
  end

  assign Master_Output = master_sr;
  assign Master_Mode   = {cpol, cpah};

endmodule

// File: tb/tb_spi_multi_slave_exchange.sv
// Scoreboard bench for spi_multi_slave_exchange: directed byte swaps in all four SPI modes.
module tb_spi_multi_slave_exchange;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] Master_Input = '0;
  logic [7:0] Selected_Slave_Input = '0;
  logic [1:0] choose = '0;
  logic       cpah = 1'b0;
  logic       cpol = 1'b0;
  logic [7:0] Master_Output;
  logic [7:0] Slave_Output;
  logic [1:0] Master_Mode;

  spi_multi_slave_exchange #(.WIDTH(8), .NUM_SLAVES(3)) dut (
    .clk                  (clk),
    .reset                (reset),
    .Master_Input         (Master_Input),
    .Selected_Slave_Input (Selected_Slave_Input),
    .choose               (choose),
    .cpah                 (cpah),
    .cpol                 (cpol),
    .Master_Output        (Master_Output),
    .Slave_Output         (Slave_Output),
    .Master_Mode          (Master_Mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] mode;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic strobe   = 1'b0;

  task automatic expect_out(input string name, input logic [7:0] m, input logic [7:0] s,
                            input logic [1:0] mode);
    exp_t e;
    e.name = name;
    e.m    = m;
    e.s    = s;
    e.mode = mode;
    sb_q.push_back(e);
    strobe = 1'b1;
    #1 strobe = 1'b0;
  endtask

  // Waits for n active shift edges of the current mode, then settles away from the edge.
  task automatic wait_shift(input int n);
    repeat (n) begin
      if (cpol ^ cpah) @(negedge clk);
      else @(posedge clk);
    end
    #2;
  endtask

  task automatic load(input logic p, input logic h, input logic [1:0] ch,
                      input logic [7:0] mi, input logic [7:0] si);
    choose               = ch;
    Master_Input         = mi;
    Selected_Slave_Input = si;
    cpol                 = p;
    cpah                 = h;
    #1 reset = 1'b1;
    wait_shift(1);
  endtask

  // Monitor: pops the expected record whenever the stimulus side raises the sample strobe.
  initial begin
    forever begin
      @(posedge strobe);
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: sample with no expected entry");
      end else begin
        cur = sb_q.pop_front();
        n_checks++;
        if (Master_Output === cur.m && Slave_Output === cur.s && Master_Mode === cur.mode)
          n_pass++;
        else
          $display("FAIL %s: got master=%b slave=%b mode=%b, want master=%b slave=%b mode=%b",
                   cur.name, Master_Output, Slave_Output, Master_Mode, cur.m, cur.s, cur.mode);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    // Mode 0, slave 1
    load(1'b0, 1'b0, 2'b00, 8'b10011001, 8'b01100110);
    expect_out("m0_reset_load", 8'b10011001, 8'b01100110, 2'b00);
    reset = 1'b0;
    wait_shift(1);
    expect_out("m0_shift1", 8'b01001100, 8'b10110011, 2'b00);
    wait_shift(7);
    expect_out("m0_shift8", 8'b01100110, 8'b10011001, 2'b00);
    wait_shift(3);
    expect_out("m0_hold", 8'b01100110, 8'b10011001, 2'b00);

    // Mode 2, slave 2
    load(1'b1, 1'b0, 2'b01, 8'b10011001, 8'b11110000);
    reset = 1'b0;
    wait_shift(8);
    expect_out("m2_swap", 8'b11110000, 8'b10011001, 2'b10);

    // Mode 3, slave 3
    load(1'b1, 1'b1, 2'b10, 8'b10011001, 8'b00001111);
    reset = 1'b0;
    wait_shift(8);
    expect_out("m3_swap", 8'b00001111, 8'b10011001, 2'b11);

    // Mode 1, slave 3 again; earlier slaves must be untouched
    load(1'b0, 1'b1, 2'b10, 8'b10011001, 8'b10101100);
    reset = 1'b0;
    wait_shift(4);
    expect_out("m1_shift4", 8'b11001001, 8'b10011010, 2'b01);
    wait_shift(4);
    expect_out("m1_swap", 8'b10101100, 8'b10011001, 2'b01);
    wait_shift(2);
    choose = 2'b00;
    #1 expect_out("m1_slave1_kept", 8'b10101100, 8'b10011001, 2'b01);
    choose = 2'b01;
    #1 expect_out("m1_slave2_kept", 8'b10101100, 8'b10011001, 2'b01);

    // Reset after 3 shifts reloads instantly, then a full swap follows
    load(1'b0, 1'b0, 2'b00, 8'b10011001, 8'b01100110);
    reset = 1'b0;
    wait_shift(3);
    expect_out("abort_shift3", 8'b11010011, 8'b00101100, 2'b00);
    reset = 1'b1;
    #1 expect_out("abort_reload", 8'b10011001, 8'b01100110, 2'b00);
    wait_shift(1);
    reset = 1'b0;
    wait_shift(8);
    expect_out("abort_swap", 8'b01100110, 8'b10011001, 2'b00);

    // No slave selected: nothing moves
    load(1'b0, 1'b0, 2'b11, 8'b10100101, 8'b00111100);
    reset = 1'b0;
    wait_shift(10);
    expect_out("none_selected", 8'b10100101, 8'b00000000, 2'b00);

    #5;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_multi_slave_exchange.md
Name: spi_multi_slave_exchange

Overview:
- Self-contained SPI subsystem: one SPI master plus three identical 8-bit SPI slaves on a shared MOSI/MISO/SCLK bus.
- On reset, the master and the selected slave preload their shift registers. After reset releases, 8 full-duplex bit transfers (LSB first) swap the two bytes.
- Used as a protocol prototype/test vehicle. The master has the behaviour of master_spi; each slave has the behaviour of slave1_spi.

Parameters:
- WIDTH, 8, shift-register and data-port width.
- NUM_SLAVES, 3, number of slave instances (choose encodings 0..NUM_SLAVES-1 valid).

Ports:
- clk  input  1  system clock; one SPI bit per clk period.
- reset  input  1  asynchronous, active-high; also acts as the parallel-load strobe.
- Master_Input  input  8  byte loaded into master shift register during reset.
- Selected_Slave_Input  input  8  byte loaded into the selected slave during reset.
- choose  input  2  slave select: 00=slave1, 01=slave2, 10=slave3, 11=none.
- cpah  input  1  clock phase (CPHA).
- cpol  input  1  clock polarity (CPOL).
- Master_Output  output  8  master shift-register contents.
- Slave_Output  output  8  selected slave's shift-register contents.
- Master_Mode  output  2  SPI mode {cpol, cpah}.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Master_Mode is combinational: {cpol, cpah}.
- Reset asserted, asynchronously and held while high:
  - master_sr = Master_Input.
  - Selected slave's sr = Selected_Slave_Input.
  - Unselected slaves keep their prior contents.
  - bit_cnt = 0, done = 0, all slave selects (ssN, active-low) = 1, sclk = cpol.
- Power-up contents of unselected slaves are undefined until each has been loaded at least once.
- Active shift edge:
  - Modes 0 and 3 (cpol^cpah=0): rising edge of clk.
  - Modes 1 and 2: falling edge of clk.
  - Outputs are therefore stable at the opposite clk edge.
- Transfer: starts at the first active edge after reset deasserts, only if choose != 11.
  - While active, ss of the chosen slave = 0; sclk = clk (mode 0/1) or ~clk (mode 2/3) toggles.
  - MOSI = master_sr[0]; MISO = selected slave sr[0].
  - Each active edge updates both registers simultaneously from pre-edge values: master_sr <= {MISO, master_sr[7:1]}; slave_sr <= {MOSI, slave_sr[7:1]}; bit_cnt++.
  - Latency: one shift per clk period. After exactly 8 shifts, master and slave bytes are exchanged.
- Completion: at bit_cnt == 8, done = 1, shifting stops, ss returns to 1, sclk returns to cpol. Registers hold until the next reset.
- choose == 11: no slave selected, MISO = 0, no shifting occurs, Slave_Output = 8'h00.
- Slave_Output is a combinational mux of the selected slave's sr and follows choose immediately.
- Changing choose mid-transfer is not supported; the transfer continues with the slave selected at reset release.
- Reset mid-transfer aborts and reloads immediately; the next transfer restarts at bit 0.
- Changing cpol/cpah is legal only while reset is high.
- Each slave receives both cpol and cpah.
- Only the selected slave drives MISO, via an internal mux; no tristates.

Test Plan:
- Mode 0, choose=00, Master_Input=10011001, Selected_Slave_Input=01100110, reset 1 clk then release:
  - After shift 1: Master_Output=01001100, Slave_Output=10110011.
  - After shift 8: Master_Output=01100110, Slave_Output=10011001; no further change.
- Mode 2 (cpol=1, cpah=0), choose=01, slave 11110000, master 10011001 → after 8 negedge shifts master=11110000, slave=10011001; Master_Mode=10.
- Mode 3, choose=10, slave 00001111, master 10011001 → after 8 posedge shifts master=00001111, slave=10011001; Master_Mode=11.
- Mode 1, choose=10, slave 10101100 → swap completes after 8 falling-edge shifts: master=10101100, slave=10011001; the other slaves' contents are unchanged.
- Reset asserted after 3 shifts → both registers reload instantly to the input values; a full 8-shift swap follows after release.
- choose=11 with reset released → Master_Output stays at Master_Input, Slave_Output=00000000, sclk stays at cpol.
